// File: rtl/crc_ctrl_pkg.sv
// Shared types and constants for the CRC-16/CCITT frame controller.
// Holds the FSM state encoding and the CRC init/polynomial/residue values.
package crc_ctrl_pkg;

    localparam logic [15:0] CRC_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC_POLY    = 16'h1021;
    localparam logic [15:0] CRC_RESIDUE = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_EMIT,
        ST_CRC_HI,
        ST_CRC_LO,
        ST_VERDICT,
        ST_INIT
    } state_t;

    // Bit of a byte consumed on a given shift step, honouring bit order.
    function automatic logic bit_sel(
        input logic [7:0] b,
        input logic [2:0] idx,
        input logic       msb_first
    );
        logic [2:0] w_pos;
        w_pos = msb_first ? (3'd7 - idx) : idx;
        return b[w_pos];
    endfunction

endpackage

// File: rtl/crc16_serial_engine.sv
// Bit-serial CRC-16/CCITT LFSR, one bit per enabled cycle, non-reflected.
// Ports: clk, reset (sync, high), enable, init, data_in, crc_out[15:0].
module crc16_serial_engine
    import crc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        init,
    input  logic        data_in,
    output logic [15:0] crc_out
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb = data_in ^ r_lfsr[15];

    always_ff @(posedge clk) begin
        if (reset || init) begin
            r_lfsr <= CRC_INIT;
        end else if (enable) begin
            r_lfsr <= {r_lfsr[14:0], 1'b0} ^ (w_fb ? CRC_POLY : 16'h0000);
        end
    end

    assign crc_out = r_lfsr;

endmodule

// File: rtl/crc_frame_ctrl.sv
// Byte-stream CRC frame controller: appends (generate) or verifies (check)
// a trailing CRC-16/CCITT. Ports: clk, reset, mode, in_* / out_* byte
// streams, crc_ok/crc_err verdict pulses, busy, crc_value (LFSR contents).
module crc_frame_ctrl
    import crc_ctrl_pkg::*;
#(
    parameter int MSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        crc_ok,
    output logic        crc_err,
    output logic        busy,
    output logic [15:0] crc_value
);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_byte;
    logic        r_last;
    logic        r_mode;
    logic        r_first;
    logic [2:0]  r_cnt;

    logic        w_accept;
    logic        w_en;
    logic        w_init;
    logic        w_bit;
    logic [15:0] w_crc;
    logic        w_in_ready;
    logic        w_out_valid;
    logic [7:0]  w_out_data;
    logic        w_out_last;
    logic        w_ok;
    logic        w_err;

    localparam logic LP_MSB = (MSB_FIRST != 0);

    assign w_accept = in_valid && w_in_ready;
    assign w_bit    = bit_sel(r_byte, r_cnt, LP_MSB);

    crc16_serial_engine u_engine (
        .clk     (clk),
        .reset   (reset),
        .enable  (w_en),
        .init    (w_init),
        .data_in (w_bit),
        .crc_out (w_crc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // r_first marks that the next accepted byte opens a new frame,
    // which is the only point where mode is captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte  <= 8'h00;
            r_last  <= 1'b0;
            r_mode  <= 1'b0;
            r_first <= 1'b1;
            r_cnt   <= 3'd0;
        end else begin
            if (w_accept) begin
                r_byte  <= in_data;
                r_last  <= in_last;
                r_first <= in_last;
                if (r_first) begin
                    r_mode <= mode;
                end
            end
            if (w_en) begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_out_data  = r_byte;
        w_out_last  = 1'b0;
        w_en        = 1'b0;
        w_init      = 1'b0;
        w_ok        = 1'b0;
        w_err       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_en = 1'b1;
                if (r_cnt == 3'd7) begin
                    w_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                w_out_valid = 1'b1;
                w_out_last  = r_last && r_mode;
                if (out_ready) begin
                    if (!r_last) begin
                        w_next = ST_IDLE;
                    end else if (r_mode) begin
                        w_next = ST_VERDICT;
                    end else begin
                        w_next = ST_CRC_HI;
                    end
                end
            end
            ST_CRC_HI: begin
                w_out_valid = 1'b1;
                w_out_data  = w_crc[15:8];
                if (out_ready) begin
                    w_next = ST_CRC_LO;
                end
            end
            ST_CRC_LO: begin
                w_out_valid = 1'b1;
                w_out_data  = w_crc[7:0];
                w_out_last  = 1'b1;
                if (out_ready) begin
                    w_next = ST_INIT;
                end
            end
            ST_VERDICT: begin
                w_ok   = (w_crc == CRC_RESIDUE);
                w_err  = (w_crc != CRC_RESIDUE);
                w_next = ST_INIT;
            end
            ST_INIT: begin
                w_init = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = w_out_data;
    assign out_last  = w_out_last;
    assign crc_ok    = w_ok;
    assign crc_err   = w_err;
    assign busy      = (r_state != ST_IDLE);
    assign crc_value = w_crc;

endmodule

// File: doc/crc_frame_ctrl.md
CRC_FRAME_CTRL -- requirements
Module: crc_frame_ctrl

Interface
REQ-001 The block SHALL have parameter MSB_FIRST, default 1, selecting bit order of byte serialization (1: bit 7 first; 0: bit 0 first).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge clk.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port mode, input, 1 bit: 0 = generate (append CRC), 1 = check (verify trailing CRC); sampled only with a frame's first byte.
REQ-005 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, 8) and in_last (input, 1): the byte input stream; in_last marks the final byte of a frame.
REQ-006 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 8) and out_last (output, 1): the byte output stream.
REQ-007 The block SHALL have ports crc_ok and crc_err, outputs, 1 bit each: single-cycle check-mode verdict pulses.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 The block SHALL have port crc_value, output, 16 bits: the current LFSR contents.

Function
REQ-010 The CRC SHALL be CCITT: polynomial 0x1021, init 0xFFFF, non-reflected, no final XOR, one bit per enabled cycle, feedback = data_bit XOR lfsr[15].
REQ-011 The FSM SHALL have states IDLE, SHIFT, EMIT, CRC_HI, CRC_LO, VERDICT, INIT.
REQ-012 in_ready SHALL be 1 only in IDLE; a byte SHALL be accepted when in_valid && in_ready, latching in_data, in_last, and mode on the frame's first byte.
REQ-013 On acceptance the FSM SHALL go to SHIFT for exactly 8 cycles, with the engine enabled one bit per cycle in the MSB_FIRST order, using a 3-bit counter that wraps 7->0.
REQ-014 After SHIFT the FSM SHALL go to EMIT, with out_valid=1, out_data = the latched byte, and out_last = latched in_last && mode==1.
REQ-015 out_data and out_last SHALL stay stable while out_valid && !out_ready, and the engine SHALL NOT be enabled outside SHIFT.
REQ-016 The EMIT handshake SHALL select the next state: not last -> IDLE; last and generate -> CRC_HI; last and check -> VERDICT.
REQ-017 CRC_HI SHALL present crc_value[15:8] and CRC_LO SHALL present crc_value[7:0] with out_last=1, each held until out_ready; CRC_LO then goes to INIT.
REQ-018 VERDICT SHALL last 1 cycle and pulse crc_ok if crc_value == 0x0000, else crc_err, then go to INIT; crc_ok and crc_err SHALL never both be high.
REQ-019 INIT SHALL last 1 cycle and assert the engine init, loading 0xFFFF, then go to IDLE; latency from last-byte handshake to in_ready is 2 cycles (check) or 3 cycles plus CRC handshakes (generate).
REQ-020 A one-byte frame (in_last on the first byte) SHALL be handled identically, with no special case.
REQ-021 The byte-level minimum occupancy SHALL be 1 (accept) + 8 (shift) + 1 (emit) = 10 cycles with out_ready tied high.

Reset
REQ-022 Reset SHALL take priority over all activity, including mid-SHIFT and mid-EMIT.
REQ-023 On reset: state=IDLE, lfsr=0xFFFF, bit counter=0, in_ready=1 on the following cycle, and out_valid, out_last, crc_ok, crc_err and busy = 0.
REQ-024 A partially processed frame SHALL be discarded on reset, with no output produced for it.

Structure
REQ-025 Package crc_ctrl_pkg SHALL hold the FSM state enum, CRC_INIT=16'hFFFF, CRC_POLY=16'h1021 and CRC_RESIDUE=16'h0000.
REQ-026 The bit-serial LFSR SHALL be a separate sub-module, crc16_serial_engine, with ports clk, reset, enable, init, data_in and crc_out[15:0], instantiated once.
REQ-027 The FSM, byte register and bit counter SHALL reside in crc_frame_ctrl.

Verification
REQ-028 Generate, "123456789" (0x31..0x39), out_ready=1 -> output SHALL be the 9 bytes unchanged, then 0x29, 0xB1 with out_last on 0xB1; each byte SHALL take 10 cycles.
REQ-029 Check, 0x31..0x39,0x29,0xB1 -> one crc_ok pulse after the last EMIT, crc_err=0, and 11 bytes out with out_last on 0xB1.
REQ-030 Check, same frame with final byte 0xB0 -> one crc_err pulse, crc_ok=0; the next frame SHALL start from 0xFFFF.
REQ-031 Generate, out_ready held 0 for 5 cycles in EMIT and CRC_HI -> out_data stable, in_ready=0, crc_value unchanged.
REQ-032 Reset asserted on SHIFT cycle 4 of byte 3 -> next cycle IDLE, crc_value=0xFFFF; a following "123456789" frame SHALL yield 0x29B1.
REQ-033 MSB_FIRST=0, generate, random frames -> output CRC SHALL match a reference model with bit-reversed byte input.
